// File: rtl/jtcop_pkg.sv
// jtcop_pkg: definitions shared by the object DMA engine and the CPU side.
//   - objdma_state_t : object DMA controller states
//   - OBJ_TABLE_AW / OBJ_TABLE_WORDS : default sprite table geometry
//   - obj_page_t : object RAM page encoding, matching jtcop_main's mixpsel bit
package jtcop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COPY = 2'd1,
      ST_SWAP = 2'd2
   } objdma_state_t;

   localparam int OBJ_TABLE_AW    = 10;
   localparam int OBJ_TABLE_WORDS = 1 << OBJ_TABLE_AW;

   // mixpsel=0 selects the low object RAM page, mixpsel=1 the high one
   typedef enum logic {
      OBJ_PAGE_LO = 1'b0,
      OBJ_PAGE_HI = 1'b1
   } obj_page_t;

endpackage

// File: rtl/jtcop_objdma_pipe.sv
// jtcop_objdma_pipe: LAT-deep tag shift register that pairs each object RAM
// read with the cycle its data comes back.
//   clk, rstn : clock, asynchronous active-low reset (clears valid tags only)
//   vld_i     : a read is presented on the RAM address this cycle
//   idx_i     : table index of that read
//   vld_o     : RAM data for a tagged read is valid this cycle
//   idx_o     : table index belonging to that data
module jtcop_objdma_pipe #(
   parameter int AW  = 10,
   parameter int LAT = 1
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          vld_i,
   input  logic [AW-1:0] idx_i,
   output logic          vld_o,
   output logic [AW-1:0] idx_o
);

   logic [LAT-1:0] vld_q;
   logic [AW-1:0]  idx_q [LAT];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= vld_i;
         for (int s = 1; s < LAT; s++) vld_q[s] <= vld_q[s-1];
      end
   end

   // index travels with its valid bit; only meaningful when the tag is valid
   always_ff @(posedge clk) begin
      idx_q[0] <= idx_i;
      for (int s = 1; s < LAT; s++) idx_q[s] <= idx_q[s-1];
   end

   assign vld_o = vld_q[LAT-1];
   assign idx_o = idx_q[LAT-1];

endmodule

// File: rtl/jtcop_objdma.sv
// jtcop_objdma: object-list DMA. On a CPU obj_copy request it copies one
// 2**AW-word sprite table from object RAM page mixpsel into the hidden half of
// a double-buffered object buffer, then flips halves at the next start of
// vertical blank so the renderer only ever scans a complete list.
//   clk, rstn : clock, asynchronous active-low reset
//   cen       : read pacing, at most one RAM read issued per cen cycle
//   LVBL      : vertical blank, active low (swap on its falling edge)
//   obj_copy  : CPU copy strobe (level, edge detected here)
//   mixpsel   : source page, sampled when a copy starts
//   src_addr  : object RAM read address {page, index}
//   src_dout  : object RAM data, LAT cycles after src_addr
//   buf_we/buf_addr/buf_din : object buffer write port {wr_bank, index}
//   disp_bank : bank read by the renderer (wr_bank = ~disp_bank)
//   busy      : copy in progress or swap pending
//   done      : one-cycle pulse when disp_bank toggles
module jtcop_objdma
   import jtcop_pkg::*;
#(
   parameter int AW  = OBJ_TABLE_AW,
   parameter int LAT = 1
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          cen,
   input  logic          LVBL,
   input  logic          obj_copy,
   input  logic          mixpsel,
   output logic [AW:0]   src_addr,
   input  logic [15:0]   src_dout,
   output logic          buf_we,
   output logic [AW:0]   buf_addr,
   output logic [15:0]   buf_din,
   output logic          disp_bank,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

   objdma_state_t state_q, state_d;
   obj_page_t     page_q, page_d;
   logic          obj_copy_q, lvbl_q;
   logic          pending_q, pending_d;
   logic [AW:0]   rd_idx_q, rd_idx_d;
   logic [AW:0]   wr_idx_q, wr_idx_d;
   logic          disp_bank_q, disp_bank_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          buf_we_q, buf_we_d;
   logic [AW:0]   buf_addr_q, buf_addr_d;
   logic [15:0]   buf_din_q, buf_din_d;

   logic          req, lvbl_fall, rd_issue, tag_vld;
   logic [AW-1:0] tag_idx;

   assign req       = obj_copy & ~obj_copy_q;
   assign lvbl_fall = lvbl_q & ~LVBL;
   // the counter MSB marks the whole table as issued
   assign rd_issue  = (state_q == ST_COPY) & cen & ~rd_idx_q[AW];

   // address is combinational so the read and its tag enter the same cycle
   assign src_addr  = {(page_q == OBJ_PAGE_HI), rd_idx_q[AW-1:0]};

   jtcop_objdma_pipe #(
      .AW  (AW),
      .LAT (LAT)
   ) u_pipe (
      .clk   (clk),
      .rstn  (rstn),
      .vld_i (rd_issue),
      .idx_i (rd_idx_q[AW-1:0]),
      .vld_o (tag_vld),
      .idx_o (tag_idx)
   );

   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      pending_d   = pending_q;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      disp_bank_d = disp_bank_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      buf_we_d    = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_din_d   = buf_din_q;

      // requests arriving while busy collapse into a single pending copy
      if (req) pending_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (req || pending_q) begin
               page_d    = mixpsel ? OBJ_PAGE_HI : OBJ_PAGE_LO;
               rd_idx_d  = '0;
               wr_idx_d  = '0;
               pending_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_COPY;
            end
         end
         ST_COPY: begin
            if (rd_issue) rd_idx_d = rd_idx_q + IDX_ONE;
            // writes follow returning data regardless of cen
            if (tag_vld) begin
               buf_we_d   = 1'b1;
               buf_addr_d = {~disp_bank_q, tag_idx};
               buf_din_d  = src_dout;
               wr_idx_d   = wr_idx_q + IDX_ONE;
               if (wr_idx_d[AW]) state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            if (lvbl_fall) begin
               disp_bank_d = ~disp_bank_q;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         page_q      <= OBJ_PAGE_LO;
         obj_copy_q  <= 1'b0;
         lvbl_q      <= 1'b0;
         pending_q   <= 1'b0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         disp_bank_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         page_q      <= page_d;
         obj_copy_q  <= obj_copy;
         lvbl_q      <= LVBL;
         pending_q   <= pending_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         disp_bank_q <= disp_bank_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_din_q   <= buf_din_d;
      end
   end

   assign buf_we    = buf_we_q;
   assign buf_addr  = buf_addr_q;
   assign buf_din   = buf_din_q;
   assign disp_bank = disp_bank_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
